// File: rtl/food_spawn_ctrl.sv
// Food placement sequencer. It tries random cells first. If every random try
// collides, it scans the grid in row-major order, starting at the last random cell.
module food_spawn_ctrl #(
  parameter int GRID_BITS = 4,
  parameter int MAX_TRIES = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_spawn_req,
  input  logic [GRID_BITS-1:0] i_rand_x,
  input  logic [GRID_BITS-1:0] i_rand_y,
  output logic                 o_occ_rd_en,
  output logic [GRID_BITS-1:0] o_occ_x,
  output logic [GRID_BITS-1:0] o_occ_y,
  input  logic                 i_occ_hit,
  output logic [GRID_BITS-1:0] o_food_x,
  output logic [GRID_BITS-1:0] o_food_y,
  output logic                 o_food_valid,
  output logic                 o_done,
  output logic                 o_busy,
  output logic                 o_board_full
);

  localparam int TRY_BITS  = $clog2(MAX_TRIES + 1);
  localparam int SCAN_BITS = 2 * GRID_BITS;
  localparam logic [TRY_BITS-1:0]  TRY_LAST  = TRY_BITS'(MAX_TRIES);
  localparam logic [SCAN_BITS-1:0] SCAN_LAST = '1;
  localparam logic [GRID_BITS-1:0] X_LAST    = '1;

  typedef enum logic [2:0] {
    IDLE,
    RAND_Q,
    RAND_W,
    SCAN_Q,
    SCAN_W,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [GRID_BITS-1:0] cand_x, cand_y;
  logic [TRY_BITS-1:0]  tries;
  logic [SCAN_BITS-1:0] scan_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_spawn_req) state_nxt = RAND_Q;
      RAND_Q:  state_nxt = RAND_W;
      RAND_W: begin
        if (!i_occ_hit)             state_nxt = DONE;
        else if (tries == TRY_LAST) state_nxt = SCAN_Q;
        else                        state_nxt = RAND_Q;
      end
      SCAN_Q:  state_nxt = SCAN_W;
      SCAN_W: begin
        if (!i_occ_hit || scan_cnt == SCAN_LAST) state_nxt = DONE;
        else                                     state_nxt = SCAN_Q;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_occ_rd_en = (state == RAND_Q) || (state == SCAN_Q);
    o_done      = (state == DONE);
    o_busy      = (state != IDLE);
  end

  assign o_occ_x = cand_x;
  assign o_occ_y = cand_y;

  // The scan needs no re-seed. cand still holds the last random cell when the scan starts.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cand_x       <= '0;
      cand_y       <= '0;
      tries        <= '0;
      scan_cnt     <= '0;
      o_food_x     <= '0;
      o_food_y     <= '0;
      o_food_valid <= 1'b0;
      o_board_full <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_spawn_req) begin
            cand_x       <= i_rand_x;
            cand_y       <= i_rand_y;
            tries        <= TRY_BITS'(1);
            o_food_valid <= 1'b0;
            o_board_full <= 1'b0;
          end
        end
        RAND_W: begin
          if (!i_occ_hit) begin
            o_food_x     <= cand_x;
            o_food_y     <= cand_y;
            o_food_valid <= 1'b1;
          end else if (tries == TRY_LAST) begin
            scan_cnt <= '0;
          end else begin
            cand_x <= i_rand_x;
            cand_y <= i_rand_y;
            tries  <= tries + TRY_BITS'(1);
          end
        end
        SCAN_W: begin
          if (!i_occ_hit) begin
            o_food_x     <= cand_x;
            o_food_y     <= cand_y;
            o_food_valid <= 1'b1;
          end else if (scan_cnt == SCAN_LAST) begin
            o_board_full <= 1'b1;
          end else begin
            cand_x   <= cand_x + GRID_BITS'(1);
            if (cand_x == X_LAST) cand_y <= cand_y + GRID_BITS'(1);
            scan_cnt <= scan_cnt + SCAN_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/food_spawn_ctrl.md
Name: food_spawn_ctrl

Overview:
- Sequences the pseudo-random coordinate generator to place a new food item on the 16x16 snake grid.
- On request, samples the free-running random X/Y, queries the snake-body occupancy map, and retries on collision.
- After MAX_TRIES collisions, falls back to a deterministic row-major scan; reports board-full if no cell is free.
- Sits between the game FSM (requester), the random generator (data source) and the body occupancy RAM (checker).

Parameters:
- GRID_BITS, 4, bits per coordinate; grid is 2^GRID_BITS square.
- MAX_TRIES, 8, random attempts before fallback scan (1..255).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_spawn_req  in  1  one-cycle request for new food; ignored while o_busy=1
- i_rand_x  in  GRID_BITS  current random X from generator
- i_rand_y  in  GRID_BITS  current random Y from generator
- o_occ_rd_en  out  1  occupancy query strobe
- o_occ_x  out  GRID_BITS  query X
- o_occ_y  out  GRID_BITS  query Y
- i_occ_hit  in  1  1 = queried cell occupied; valid exactly 1 cycle after o_occ_rd_en
- o_food_x  out  GRID_BITS  placed food X
- o_food_y  out  GRID_BITS  placed food Y
- o_food_valid  out  1  food coordinates valid
- o_done  out  1  one-cycle pulse: request finished (success or full)
- o_busy  out  1  high from cycle after accept until the o_done cycle inclusive
- o_board_full  out  1  last request found no free cell

Behaviour:
- Reset (synchronous): state IDLE; all outputs 0; cand, tries, scan_cnt cleared. Reset mid-operation aborts immediately; no o_done is issued.
- States: IDLE, RAND_Q, RAND_W, SCAN_Q, SCAN_W, DONE.
- IDLE:
  - On i_spawn_req: cand <= {i_rand_x, i_rand_y}, tries <= 1, o_food_valid <= 0, o_board_full <= 0, go to RAND_Q.
- RAND_Q: o_occ_rd_en = 1, o_occ_x/y = cand; go to RAND_W.
- RAND_W: evaluate i_occ_hit.
  - Not hit: food <= cand, go to DONE.
  - Hit and tries == MAX_TRIES: scan_cnt <= 0, keep cand as scan start, go to SCAN_Q.
  - Otherwise: cand <= current i_rand_x/y, tries++, go to RAND_Q.
- SCAN_Q: query cand; go to SCAN_W.
- SCAN_W: evaluate i_occ_hit.
  - Not hit: food <= cand, go to DONE.
  - Hit and scan_cnt == 2^(2*GRID_BITS)-1: o_board_full <= 1, go to DONE with o_food_valid staying 0.
  - Otherwise: advance cand row-major (x+1; on x wrap to 0, y+1; y wraps to 0), scan_cnt++, go to SCAN_Q.
- DONE:
  - o_done = 1 for one cycle.
  - o_food_valid = 1 unless board full.
  - Go to IDLE. A request arriving in the DONE cycle is ignored.
- o_food_x/y hold the last successful placement until the next success. They are not cleared on request.
- o_occ_x/y are don't-care when o_occ_rd_en = 0, but must be driven from cand.
- Latency:
  - Best case: req accepted in cycle 0, query in cycle 1, evaluated in cycle 2, o_done in cycle 3.
  - Each retry adds 2 cycles.
  - Worst case (full board): 3 + 2*MAX_TRIES + 2*2^(2*GRID_BITS) - 2 cycles = 529 for defaults.
- Counters: tries is ceil(log2(MAX_TRIES+1)) bits; scan_cnt is 2*GRID_BITS bits. Neither may overflow.
- o_busy = (state != IDLE).

Test Plan:
- Empty board: req with rand=(5,9), hit=0 -> one query at (5,9) in cycle 1; o_done and o_food_valid in cycle 3 with food=(5,9); o_busy high cycles 1-3.
- Two collisions: rand sequence (5,9),(2,2),(7,1), hits 1,1,0 -> queries at those three cells in order; food=(7,1); o_done in cycle 7.
- Fallback scan: MAX_TRIES=8, all random cells hit, start cand=(15,3); scan cells (15,3) hit and (0,4) free -> scan wraps x to 0 and y to 4; food=(0,4).
- Scan wrap: start (15,15), only (0,0) free -> second scan query is (0,0); food=(0,0).
- Board full: hit always 1 -> exactly 8+256 queries; o_done with o_board_full=1 and o_food_valid=0; next req clears o_board_full on accept.
- Reset/ignore: i_spawn_req while busy -> no effect; i_rst asserted in RAND_W -> next cycle IDLE with all outputs 0 and no o_done.
